// File: rtl/rtc_alarm_if.sv
// Signal bundle between the RTC alarm unit and its host: config bus,
// current time from the time counter, user controls, status and readback.
interface rtc_alarm_if #(
  parameter int MAX_SNOOZE = 3
) ();
  localparam int SCW = $clog2(MAX_SNOOZE + 1);

  logic           arm_i;
  logic           cfg_we_i;
  logic [5:0]     cfg_sec_i;
  logic [5:0]     cfg_min_i;
  logic [5:0]     cfg_hour_i;
  logic [1:0]     cfg_mode_i;
  logic [2:0]     cfg_dow_i;
  logic [3:0]     cfg_mask_i;
  logic           snooze_i;
  logic           stop_i;
  logic [5:0]     cur_sec_i;
  logic [5:0]     cur_min_i;
  logic [5:0]     cur_hour_i;
  logic [1:0]     cur_mode_i;
  logic [2:0]     cur_dow_i;

  logic           alarm_o;
  logic [1:0]     state_o;
  logic [SCW-1:0] snooze_cnt_o;
  logic           missed_o;
  logic           cfg_err_o;
  logic [5:0]     al_sec_o;
  logic [5:0]     al_min_o;
  logic [5:0]     al_hour_o;
  logic [1:0]     al_mode_o;
  logic [2:0]     al_dow_o;
  logic [3:0]     al_mask_o;

  modport master (
    output arm_i, cfg_we_i, cfg_sec_i, cfg_min_i, cfg_hour_i, cfg_mode_i,
           cfg_dow_i, cfg_mask_i, snooze_i, stop_i,
           cur_sec_i, cur_min_i, cur_hour_i, cur_mode_i, cur_dow_i,
    input  alarm_o, state_o, snooze_cnt_o, missed_o, cfg_err_o,
           al_sec_o, al_min_o, al_hour_o, al_mode_o, al_dow_o, al_mask_o
  );

  modport slave (
    input  arm_i, cfg_we_i, cfg_sec_i, cfg_min_i, cfg_hour_i, cfg_mode_i,
           cfg_dow_i, cfg_mask_i, snooze_i, stop_i,
           cur_sec_i, cur_min_i, cur_hour_i, cur_mode_i, cur_dow_i,
    output alarm_o, state_o, snooze_cnt_o, missed_o, cfg_err_o,
           al_sec_o, al_min_o, al_hour_o, al_mode_o, al_dow_o, al_mask_o
  );
endinterface

// File: rtl/rtc_alarm.sv
// RTC alarm unit: programmable alarm time/mask, match-edge detection and a
// ring/snooze state machine on the 1 Hz time base.
module rtc_alarm #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input logic        clk_1Hz_i,
  input logic        rstn_i,
  rtc_alarm_if.slave bus
);
  localparam int SCW  = $clog2(MAX_SNOOZE + 1);
  localparam int TMAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_RING   = 2'd2;
  localparam logic [1:0] ST_SNOOZE = 2'd3;

  localparam logic [TW-1:0]  RING_LOAD   = TW'(RING_SECONDS - 1);
  localparam logic [TW-1:0]  SNOOZE_LOAD = TW'(SNOOZE_SECONDS - 1);
  localparam logic [SCW-1:0] SNOOZE_MAX  = SCW'(MAX_SNOOZE);

  // Both sides compare in 24-hour form; 12 AM maps to hour 0.
  function automatic logic [5:0] to_h24(input logic [5:0] h, input logic [1:0] mode);
    logic [5:0] r;
    if (mode[0])
      r = ((h == 6'd12) ? 6'd0 : h) + (mode[1] ? 6'd12 : 6'd0);
    else
      r = h;
    return r;
  endfunction

  function automatic logic cfg_ok(input logic [5:0] s, input logic [5:0] m,
                                  input logic [5:0] h, input logic [1:0] mode,
                                  input logic [2:0] dow);
    logic h_ok;
    h_ok = mode[0] ? (h >= 6'd1 && h <= 6'd12) : (h <= 6'd23);
    return (s <= 6'd59) && (m <= 6'd59) && h_ok && (dow != 3'd0);
  endfunction

  logic [1:0]     state, state_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [SCW-1:0] snooze_cnt, cnt_nx;
  logic           match, match_q, match_rise;
  logic           missed, missed_nx;
  logic           cfg_err;
  logic           cfg_valid, cfg_take;
  logic [5:0]     al_sec, al_min, al_hour;
  logic [1:0]     al_mode;
  logic [2:0]     al_dow;
  logic [3:0]     al_mask;

  assign cfg_valid = cfg_ok(bus.cfg_sec_i, bus.cfg_min_i, bus.cfg_hour_i,
                            bus.cfg_mode_i, bus.cfg_dow_i);
  assign cfg_take  = bus.arm_i && bus.cfg_we_i && cfg_valid;

  assign match = (al_mask != 4'd0)
              && (!al_mask[0] || bus.cur_sec_i == al_sec)
              && (!al_mask[1] || bus.cur_min_i == al_min)
              && (!al_mask[2] || to_h24(bus.cur_hour_i, bus.cur_mode_i) == to_h24(al_hour, al_mode))
              && (!al_mask[3] || bus.cur_dow_i == al_dow);
  assign match_rise = match && !match_q;

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    cnt_nx    = snooze_cnt;
    missed_nx = 1'b0;
    if (!bus.arm_i) begin
      state_nx = ST_IDLE;
      timer_nx = '0;
      cnt_nx   = '0;
    end else if (cfg_take) begin
      state_nx = ST_ARMED;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_ARMED;
        ST_ARMED: begin
          if (match_rise) begin
            state_nx = ST_RING;
            timer_nx = RING_LOAD;
          end
        end
        ST_RING: begin
          if (bus.stop_i) begin
            state_nx = ST_ARMED;
            cnt_nx   = '0;
          end else if (bus.snooze_i && snooze_cnt < SNOOZE_MAX) begin
            state_nx = ST_SNOOZE;
            timer_nx = SNOOZE_LOAD;
            cnt_nx   = snooze_cnt + SCW'(1);
          end else if (timer == '0) begin
            state_nx  = ST_ARMED;
            cnt_nx    = '0;
            missed_nx = 1'b1;
          end else begin
            timer_nx = timer - TW'(1);
          end
        end
        default: begin
          if (bus.stop_i) begin
            state_nx = ST_ARMED;
            cnt_nx   = '0;
          end else if (timer == '0) begin
            state_nx = ST_RING;
            timer_nx = RING_LOAD;
          end else begin
            timer_nx = timer - TW'(1);
          end
        end
      endcase
    end
  end

  // State / timer / status register stage
  always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      timer      <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b0;
      missed     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      snooze_cnt <= cnt_nx;
      match_q    <= match;
      missed     <= missed_nx;
      cfg_err    <= bus.cfg_we_i && !cfg_valid;
    end
  end

  // Latched alarm configuration; the PM bit is meaningless in 24-hour form
  always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      al_sec  <= 6'd0;
      al_min  <= 6'd0;
      al_hour <= 6'd0;
      al_mode <= 2'b00;
      al_dow  <= 3'd1;
      al_mask <= 4'b0111;
    end else if (cfg_take) begin
      al_sec  <= bus.cfg_sec_i;
      al_min  <= bus.cfg_min_i;
      al_hour <= bus.cfg_hour_i;
      al_mode <= {bus.cfg_mode_i[1] & bus.cfg_mode_i[0], bus.cfg_mode_i[0]};
      al_dow  <= bus.cfg_dow_i;
      al_mask <= bus.cfg_mask_i;
    end
  end

  assign bus.alarm_o      = (state == ST_RING);
  assign bus.state_o      = state;
  assign bus.snooze_cnt_o = snooze_cnt;
  assign bus.missed_o     = missed;
  assign bus.cfg_err_o    = cfg_err;
  assign bus.al_sec_o     = al_sec;
  assign bus.al_min_o     = al_min;
  assign bus.al_hour_o    = al_hour;
  assign bus.al_mode_o    = al_mode;
  assign bus.al_dow_o     = al_dow;
  assign bus.al_mask_o    = al_mask;
endmodule

// File: tb/tb_rtc_alarm.sv
// Bench for rtc_alarm: directed time sweeps against a behavioural alarm model,
// with literal expectations at the key events.
module tb_rtc_alarm;
  localparam int RING   = 60;
  localparam int SNOOZE = 300;
  localparam int MAXS   = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  rtc_alarm_if #(.MAX_SNOOZE(MAXS)) bus ();

  rtc_alarm #(.RING_SECONDS(RING), .SNOOZE_SECONDS(SNOOZE), .MAX_SNOOZE(MAXS)) dut (
    .clk_1Hz_i(clk),
    .rstn_i   (rstn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase + cycles remaining in that phase
  int m_state, m_left, m_cnt;
  bit m_missed, m_err, m_prev;
  int a_sec, a_min, a_hour, a_mode, a_dow, a_mask;

  function automatic int hour24(int h, int mode);
    if (mode % 2 == 1) return (h % 12) + ((mode / 2) % 2) * 12;
    return h;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state = 0; m_left = 0; m_cnt = 0;
      m_missed = 0; m_err = 0; m_prev = 0;
      a_sec = 0; a_min = 0; a_hour = 0; a_mode = 0; a_dow = 1; a_mask = 7;
    end else begin
      bit hit, rise, valid;
      int ch, cm;
      hit = (a_mask != 0);
      if ((a_mask & 1) != 0 && int'(bus.cur_sec_i) != a_sec) hit = 0;
      if ((a_mask & 2) != 0 && int'(bus.cur_min_i) != a_min) hit = 0;
      if ((a_mask & 4) != 0 &&
          hour24(int'(bus.cur_hour_i), int'(bus.cur_mode_i)) != hour24(a_hour, a_mode)) hit = 0;
      if ((a_mask & 8) != 0 && int'(bus.cur_dow_i) != a_dow) hit = 0;
      rise = hit && !m_prev;
      m_prev = hit;
      ch = int'(bus.cfg_hour_i);
      cm = int'(bus.cfg_mode_i);
      valid = bus.cfg_sec_i <= 59 && bus.cfg_min_i <= 59 && bus.cfg_dow_i >= 1 &&
              ((cm % 2 == 1) ? (ch >= 1 && ch <= 12) : (ch <= 23));
      m_err = bus.cfg_we_i && !valid;
      m_missed = 0;
      if (!bus.arm_i) begin
        m_state = 0; m_left = 0; m_cnt = 0;
      end else if (bus.cfg_we_i && valid) begin
        a_sec = int'(bus.cfg_sec_i); a_min = int'(bus.cfg_min_i); a_hour = ch;
        a_mode = (cm % 2 == 1) ? cm : 0;
        a_dow = int'(bus.cfg_dow_i); a_mask = int'(bus.cfg_mask_i);
        m_state = 1; m_cnt = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (rise) begin m_state = 2; m_left = RING; end
      end else if (m_state == 2) begin
        if (bus.stop_i) begin m_state = 1; m_cnt = 0; end
        else if (bus.snooze_i && m_cnt < MAXS) begin m_state = 3; m_left = SNOOZE; m_cnt++; end
        else if (m_left == 1) begin m_state = 1; m_cnt = 0; m_missed = 1; end
        else m_left--;
      end else begin
        if (bus.stop_i) begin m_state = 1; m_cnt = 0; end
        else if (m_left == 1) begin m_state = 2; m_left = RING; end
        else m_left--;
      end
    end
  end

  always @(negedge clk) begin
    chk("alarm", 32'(bus.alarm_o), 32'(m_state == 2));
    chk("state", 32'(bus.state_o), 32'(m_state));
    chk("snooze_cnt", 32'(bus.snooze_cnt_o), 32'(m_cnt));
    chk("missed", 32'(bus.missed_o), 32'(m_missed));
    chk("cfg_err", 32'(bus.cfg_err_o), 32'(m_err));
    chk("al_time", {8'd0, 6'(bus.al_hour_o), 6'(bus.al_min_o), 6'(bus.al_sec_o), 6'd0},
        {8'd0, 6'(a_hour), 6'(a_min), 6'(a_sec), 6'd0});
    chk("al_mode_dow_mask", {23'd0, bus.al_mode_o, bus.al_dow_o, bus.al_mask_o},
        {23'd0, 2'(a_mode), 3'(a_dow), 4'(a_mask)});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int tod(int h, int m, int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tod(input int t);
    bus.cur_hour_i = 6'(t / 3600);
    bus.cur_min_i  = 6'((t / 60) % 60);
    bus.cur_sec_i  = 6'(t % 60);
    bus.cur_mode_i = 2'b00;
  endtask

  task automatic write_cfg(input int h, input int m, input int s,
                           input int mode, input int dow, input int mask);
    bus.cfg_hour_i = 6'(h);
    bus.cfg_min_i  = 6'(m);
    bus.cfg_sec_i  = 6'(s);
    bus.cfg_mode_i = 2'(mode);
    bus.cfg_dow_i  = 3'(dow);
    bus.cfg_mask_i = 4'(mask);
    bus.cfg_we_i   = 1'b1;
    cycle();
    bus.cfg_we_i   = 1'b0;
  endtask

  initial begin
    int t0, first, rc, mc, sc;
    bus.arm_i = 1'b0; bus.cfg_we_i = 1'b0; bus.snooze_i = 1'b0; bus.stop_i = 1'b0;
    bus.cfg_sec_i = '0; bus.cfg_min_i = '0; bus.cfg_hour_i = '0;
    bus.cfg_mode_i = '0; bus.cfg_dow_i = 3'd1; bus.cfg_mask_i = '0;
    bus.cur_dow_i = 3'd1;
    set_tod(0);
    repeat (2) cycle();
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_dow_mask", {25'd0, bus.al_dow_o, bus.al_mask_o}, {25'd0, 3'd1, 4'b0111});
    rstn = 1'b1;

    // 24-hour ring and timeout
    bus.arm_i = 1'b1;
    set_tod(tod(7, 29, 58));
    write_cfg(7, 30, 0, 0, 1, 4'b0111);
    chk("t1_armed", 32'(bus.state_o), 1);
    chk("t1_al_hour", 32'(bus.al_hour_o), 7);
    t0 = tod(7, 29, 58); first = -1; rc = 0; mc = 0;
    for (int i = 0; i < 70; i++) begin
      set_tod(t0 + i);
      cycle();
      if (bus.alarm_o) begin rc++; if (first < 0) first = i; end
      if (bus.missed_o) mc++;
    end
    chk("t1_first_ring", 32'(first), 2);
    chk("t1_ring_len", 32'(rc), 60);
    chk("t1_missed_cnt", 32'(mc), 1);
    chk("t1_end_state", 32'(bus.state_o), 1);

    // 12-hour midnight
    set_tod(tod(23, 59, 58));
    write_cfg(12, 0, 0, 1, 1, 4'b0111);
    chk("t2_al_mode", 32'(bus.al_mode_o), 1);
    set_tod(tod(23, 59, 59)); cycle();
    chk("t2_pre", 32'(bus.alarm_o), 0);
    set_tod(0); cycle();
    chk("t2_midnight", 32'(bus.alarm_o), 1);
    set_tod(1); bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    chk("t2_stop", 32'(bus.state_o), 1);
    bus.cur_hour_i = 6'd11; bus.cur_min_i = 6'd59; bus.cur_sec_i = 6'd59; bus.cur_mode_i = 2'b01;
    cycle();
    bus.cur_hour_i = 6'd12; bus.cur_min_i = 6'd0; bus.cur_sec_i = 6'd0; bus.cur_mode_i = 2'b11;
    cycle();
    chk("t2_noon", 32'(bus.alarm_o), 0);

    // Snooze limit
    set_tod(tod(5, 59, 59));
    write_cfg(6, 0, 0, 0, 1, 4'b0111);
    set_tod(tod(6, 0, 0)); cycle();
    chk("t3_ring", 32'(bus.alarm_o), 1);
    t0 = tod(6, 0, 1);
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin set_tod(t0); t0++; cycle(); end
      bus.snooze_i = 1'b1; set_tod(t0); t0++; cycle(); bus.snooze_i = 1'b0;
      chk("t3_snooze", 32'(bus.state_o), 3);
      chk("t3_cnt", 32'(bus.snooze_cnt_o), 32'(k + 1));
      sc = 1;
      for (int j = 0; j < 300; j++) begin
        set_tod(t0); t0++; cycle();
        if (bus.state_o == 2'd3) sc++;
      end
      chk("t3_snooze_len", 32'(sc), 300);
      chk("t3_rering", 32'(bus.state_o), 2);
    end
    bus.snooze_i = 1'b1; cycle(); bus.snooze_i = 1'b0;
    chk("t3_4th_state", 32'(bus.state_o), 2);
    chk("t3_4th_cnt", 32'(bus.snooze_cnt_o), 3);
    bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    chk("t3_stop_state", 32'(bus.state_o), 1);
    chk("t3_stop_cnt", 32'(bus.snooze_cnt_o), 0);

    // Minute mask
    set_tod(tod(8, 14, 58));
    write_cfg(8, 15, 0, 0, 1, 4'b0110);
    set_tod(tod(8, 14, 59)); cycle();
    t0 = tod(8, 15, 0);
    set_tod(t0); cycle();
    chk("t4_ring", 32'(bus.alarm_o), 1);
    for (int i = 1; i < 9; i++) begin set_tod(t0 + i); cycle(); end
    set_tod(t0 + 9); bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    chk("t4_stop", 32'(bus.state_o), 1);
    rc = 0;
    for (int i = 10; i < 70; i++) begin
      set_tod(t0 + i); cycle();
      if (bus.alarm_o) rc++;
    end
    chk("t4_no_rering", 32'(rc), 0);
    set_tod(tod(23, 59, 59)); cycle();
    bus.cur_dow_i = 3'd2;
    set_tod(tod(8, 14, 59)); cycle();
    set_tod(tod(8, 15, 0)); cycle();
    chk("t4_next_day", 32'(bus.alarm_o), 1);
    bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;

    // Config rejection
    set_tod(tod(8, 20, 0));
    write_cfg(24, 0, 0, 0, 1, 4'b0111);
    chk("t5_err1", 32'(bus.cfg_err_o), 1);
    chk("t5_hour_kept", 32'(bus.al_hour_o), 8);
    chk("t5_state_kept", 32'(bus.state_o), 1);
    cycle();
    chk("t5_err_pulse", 32'(bus.cfg_err_o), 0);
    write_cfg(0, 10, 0, 1, 1, 4'b0111);
    chk("t5_err2", 32'(bus.cfg_err_o), 1);
    chk("t5_min_kept", 32'(bus.al_min_o), 15);
    write_cfg(3, 0, 0, 2, 1, 4'b0000);
    chk("t5_mask0", 32'(bus.al_mask_o), 0);
    chk("t5_pm_dropped", 32'(bus.al_mode_o), 0);
    rc = 0;
    for (int m = 0; m < 1440; m++) begin
      set_tod(m * 60 + (m * 7) % 60); cycle();
      if (bus.alarm_o) rc++;
    end
    chk("t5_no_ring", 32'(rc), 0);

    // Config write beats stop and snooze in the same cycle
    bus.cur_dow_i = 3'd1;
    set_tod(tod(9, 59, 59));
    write_cfg(10, 0, 0, 0, 1, 4'b0111);
    set_tod(tod(10, 0, 0)); cycle();
    chk("t6_ring", 32'(bus.alarm_o), 1);
    set_tod(tod(10, 0, 1));
    bus.stop_i = 1'b1; bus.snooze_i = 1'b1;
    write_cfg(10, 0, 5, 0, 1, 4'b0111);
    bus.stop_i = 1'b0; bus.snooze_i = 1'b0;
    chk("t6_cfg_wins_state", 32'(bus.state_o), 1);
    chk("t6_cfg_wins_sec", 32'(bus.al_sec_o), 5);
    set_tod(tod(10, 0, 4)); cycle();
    set_tod(tod(10, 0, 5)); cycle();
    chk("t6_ring2", 32'(bus.alarm_o), 1);

    // Disarm mid-ring
    bus.arm_i = 1'b0; set_tod(tod(10, 0, 6)); cycle();
    chk("t6_disarm_state", 32'(bus.state_o), 0);
    chk("t6_disarm_alarm", 32'(bus.alarm_o), 0);
    bus.arm_i = 1'b1; cycle();
    chk("t6_rearm", 32'(bus.state_o), 1);
    set_tod(tod(10, 0, 4)); cycle();
    set_tod(tod(10, 0, 5)); cycle();
    bus.snooze_i = 1'b1; cycle(); bus.snooze_i = 1'b0;
    chk("t6_in_snooze", 32'(bus.state_o), 3);
    repeat (3) cycle();

    // Asynchronous reset mid-snooze
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("rst_async_state", 32'(bus.state_o), 0);
    chk("rst_async_alarm", 32'(bus.alarm_o), 0);
    chk("rst_async_cnt", 32'(bus.snooze_cnt_o), 0);
    chk("rst_async_flags", {30'd0, bus.missed_o, bus.cfg_err_o}, 0);
    chk("rst_async_time", {14'd0, bus.al_hour_o, bus.al_min_o, bus.al_sec_o}, 0);
    chk("rst_async_cfg", {23'd0, bus.al_mode_o, bus.al_dow_o, bus.al_mask_o},
        {23'd0, 2'b00, 3'd1, 4'b0111});
    cycle(); cycle();
    rstn = 1'b1;
    cycle();
    chk("post_rst_armed", 32'(bus.state_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
